// File: rtl/epoch_counter_pkg.sv
// rtl/epoch_counter_pkg.sv - shared constants, field selects and edit FSM states for epoch_counter
package epoch_pkg;

  // Edit step sizes in seconds for each selectable field.
  localparam logic [16:0] STEP_SEC  = 17'd1;
  localparam logic [16:0] STEP_MIN  = 17'd60;
  localparam logic [16:0] STEP_HOUR = 17'd3600;
  localparam logic [16:0] STEP_DAY  = 17'd86400;

  // One-hot field select encodings.
  localparam logic [3:0] SEL_SEC  = 4'b0001;
  localparam logic [3:0] SEL_MIN  = 4'b0010;
  localparam logic [3:0] SEL_HOUR = 4'b0100;
  localparam logic [3:0] SEL_DAY  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REPEAT
  } edit_state_t;

  // Zero means "no step": any select that is not exactly one known field.
  function automatic logic [16:0] step_size(input logic [3:0] sel);
    case (sel)
      SEL_SEC:  step_size = STEP_SEC;
      SEL_MIN:  step_size = STEP_MIN;
      SEL_HOUR: step_size = STEP_HOUR;
      SEL_DAY:  step_size = STEP_DAY;
      default:  step_size = 17'd0;
    endcase
  endfunction

endpackage

// File: rtl/epoch_counter_if.sv
// rtl/epoch_counter_if.sv - control and status bundle between a host and epoch_counter
interface epoch_counter_if #(
  parameter int WIDTH = 32
);

  logic             run;
  logic             edit;
  logic             inc;
  logic             dec;
  logic [3:0]       sel;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] t;
  logic             tick;
  logic             wrap;
  logic             adjust;
  logic             clamped;

  modport master (
    output run, edit, inc, dec, sel, load, load_value,
    input  t, tick, wrap, adjust, clamped
  );

  modport slave (
    input  run, edit, inc, dec, sel, load, load_value,
    output t, tick, wrap, adjust, clamped
  );

endinterface

// File: rtl/epoch_counter_edit_repeater.sv
// rtl/epoch_counter_edit_repeater.sv - button edge detect and press/auto-repeat step generator
module edit_repeater
  import epoch_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic edit,
  input  logic inc,
  input  logic dec,
  output logic step_inc,
  output logic step_dec
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  logic          inc_r, dec_r, inc_p, dec_p;
  logic          armed;
  edit_state_t   state, state_n;
  logic          dir_up, dir_up_n;
  logic [TW-1:0] timer, timer_n;
  logic          fire;
  logic          inc_edge, dec_edge;
  logic          held, opposite;

  // armed stays low after reset until both buttons are seen released, so a
  // button held through reset cannot masquerade as a fresh press.
  assign inc_edge = armed & inc_r & ~inc_p;
  assign dec_edge = armed & dec_r & ~dec_p;
  assign held     = dir_up ? inc_r : dec_r;
  assign opposite = dir_up ? dec_r : inc_r;

  // Register the raw buttons once and keep the previous sample for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_r <= 1'b0;
      dec_r <= 1'b0;
      inc_p <= 1'b0;
      dec_p <= 1'b0;
      armed <= 1'b0;
    end else begin
      inc_r <= inc;
      dec_r <= dec;
      inc_p <= inc_r;
      dec_p <= dec_r;
      armed <= armed | (~inc & ~dec);
    end
  end

  // FSM state, latched direction and cycles-since-last-step timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      dir_up <= 1'b0;
      timer  <= '0;
    end else begin
      state  <= state_n;
      dir_up <= dir_up_n;
      timer  <= timer_n;
    end
  end

  // Next state and step pulse; an abort condition always wins over a due step.
  always_comb begin
    state_n  = state;
    dir_up_n = dir_up;
    timer_n  = timer;
    fire     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (edit && inc_edge && !dec_r) begin
          state_n  = ST_WAIT;
          dir_up_n = 1'b1;
          timer_n  = T_ONE;
          fire     = 1'b1;
        end else if (edit && dec_edge && !inc_r) begin
          state_n  = ST_WAIT;
          dir_up_n = 1'b0;
          timer_n  = T_ONE;
          fire     = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!edit || !held || opposite) begin
          state_n = ST_IDLE;
          timer_n = '0;
        end else if (timer == T_DELAY) begin
          state_n = ST_REPEAT;
          timer_n = T_ONE;
          fire    = 1'b1;
        end else begin
          timer_n = timer + T_ONE;
        end
      end
      ST_REPEAT: begin
        if (!edit || !held || opposite) begin
          state_n = ST_IDLE;
          timer_n = '0;
        end else if (timer == T_PERIOD) begin
          timer_n = T_ONE;
          fire    = 1'b1;
        end else begin
          timer_n = timer + T_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        timer_n = '0;
      end
    endcase
    step_inc = fire & dir_up_n;
    step_dec = fire & ~dir_up_n;
  end

endmodule

// File: rtl/epoch_counter.sv
// rtl/epoch_counter.sv - seconds counter with prescaler, load and button-driven field editing
module epoch_counter
  import epoch_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int TICK_DIV      = 100000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int SATURATE      = 0
) (
  input  logic            clk,
  input  logic            reset,
  epoch_counter_if.slave  bus
);

  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam bit   SAT = (SATURATE != 0);

  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] t_q;
  logic             tick_q, wrap_q, adjust_q, clamped_q;
  logic             step_inc, step_dec;
  logic [16:0]      step;
  logic [WIDTH:0]   sum, diff;
  logic             pre_run, pre_end, edit_hit;

  edit_repeater #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_rep (
    .clk      (clk),
    .reset    (reset),
    .edit     (bus.edit),
    .inc      (bus.inc),
    .dec      (bus.dec),
    .step_inc (step_inc),
    .step_dec (step_dec)
  );

  // The extra top bit of sum/diff is the carry/borrow used for clamping.
  assign step     = step_size(bus.sel);
  assign sum      = {1'b0, t_q} + {{(WIDTH-16){1'b0}}, step};
  assign diff     = {1'b0, t_q} - {{(WIDTH-16){1'b0}}, step};
  assign pre_run  = bus.run & ~bus.edit;
  assign pre_end  = pre_run && (presc == PRE_LAST);
  assign edit_hit = (step_inc | step_dec) && (step != 17'd0);

  // Prescaler: load clears it, otherwise it runs only when counting is enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (bus.load) begin
      presc <= '0;
    end else if (pre_run) begin
      presc <= pre_end ? '0 : presc + 1'b1;
    end
  end

  // Count update with priority load > edit step > tick; losers are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q       <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      adjust_q  <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      adjust_q  <= 1'b0;
      clamped_q <= 1'b0;
      if (bus.load) begin
        t_q <= bus.load_value;
      end else if (edit_hit) begin
        adjust_q <= 1'b1;
        if (step_inc) begin
          if (SAT && sum[WIDTH]) begin
            t_q       <= '1;
            clamped_q <= 1'b1;
          end else begin
            t_q <= sum[WIDTH-1:0];
          end
        end else begin
          if (SAT && diff[WIDTH]) begin
            t_q       <= '0;
            clamped_q <= 1'b1;
          end else begin
            t_q <= diff[WIDTH-1:0];
          end
        end
      end else if (pre_end) begin
        t_q    <= t_q + 1'b1;
        tick_q <= 1'b1;
        wrap_q <= &t_q;
      end
    end
  end

  assign bus.t       = t_q;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign bus.adjust  = adjust_q;
  assign bus.clamped = clamped_q;

endmodule

// File: tb/tb_epoch_counter.sv
// tb/tb_epoch_counter.sv - randomized and directed self-checking bench for epoch_counter
module tb_epoch_counter;

  localparam int TD = 4;
  localparam int RD = 8;
  localparam int RP = 3;
  localparam longint TWO32 = 64'd4294967296;
  localparam longint MAXV  = 64'd4294967295;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  epoch_counter_if #(.WIDTH(32)) bus0 ();
  epoch_counter_if #(.WIDTH(32)) bus1 ();

  assign bus1.run        = bus0.run;
  assign bus1.edit       = bus0.edit;
  assign bus1.inc        = bus0.inc;
  assign bus1.dec        = bus0.dec;
  assign bus1.sel        = bus0.sel;
  assign bus1.load       = bus0.load;
  assign bus1.load_value = bus0.load_value;

  epoch_counter #(.WIDTH(32), .TICK_DIV(TD), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .SATURATE(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  epoch_counter #(.WIDTH(32), .TICK_DIV(TD), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .SATURATE(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: count for the wrapping and the clamping variant,
  // seconds progress, button history and the current press session.
  longint m_t0, m_t1;
  int     m_presc;
  bit     m_tick, m_wrap0, m_wrap1, m_adj, m_clamp1;
  bit     m_vi, m_vi_p, m_vd, m_vd_p, m_armed;
  bit     m_active, m_dir_up;
  longint m_cyc, m_start;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint model_size(input logic [3:0] s);
    case (s)
      4'b0001: return 1;
      4'b0010: return 60;
      4'b0100: return 3600;
      4'b1000: return 86400;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_t0 = 0; m_t1 = 0; m_presc = 0;
    m_tick = 0; m_wrap0 = 0; m_wrap1 = 0; m_adj = 0; m_clamp1 = 0;
    m_vi = 0; m_vi_p = 0; m_vd = 0; m_vd_p = 0; m_armed = 0;
    m_active = 0;
  endtask

  // Predict the effect of the coming clock edge from the inputs now applied.
  task automatic model_step();
    bit     step_now;
    bit     tick_ev;
    longint el, size;
    step_now = 0;
    tick_ev  = 0;
    m_tick = 0; m_wrap0 = 0; m_wrap1 = 0; m_adj = 0; m_clamp1 = 0;
    if (m_active) begin
      if (!bus0.edit || (m_dir_up ? !m_vi : !m_vd) || (m_dir_up ? m_vd : m_vi)) begin
        m_active = 0;
      end else begin
        el = m_cyc - m_start;
        if (el == RD || (el > RD && ((el - RD) % RP) == 0)) step_now = 1;
      end
    end else if (bus0.edit && m_armed) begin
      if (m_vi && !m_vi_p && !m_vd) begin
        m_active = 1; m_dir_up = 1; m_start = m_cyc; step_now = 1;
      end else if (m_vd && !m_vd_p && !m_vi) begin
        m_active = 1; m_dir_up = 0; m_start = m_cyc; step_now = 1;
      end
    end
    size = model_size(bus0.sel);
    if (bus0.load) begin
      m_t0 = longint'(bus0.load_value);
      m_t1 = longint'(bus0.load_value);
      m_presc = 0;
    end else begin
      if (bus0.run && !bus0.edit) begin
        if (m_presc == TD - 1) begin m_presc = 0; tick_ev = 1; end
        else m_presc++;
      end
      if (step_now && size != 0) begin
        m_adj = 1;
        if (m_dir_up) begin
          m_t0 = (m_t0 + size) % TWO32;
          if (m_t1 + size > MAXV) begin m_t1 = MAXV; m_clamp1 = 1; end
          else m_t1 = m_t1 + size;
        end else begin
          m_t0 = (m_t0 + TWO32 - size) % TWO32;
          if (m_t1 < size) begin m_t1 = 0; m_clamp1 = 1; end
          else m_t1 = m_t1 - size;
        end
      end else if (tick_ev) begin
        m_tick  = 1;
        m_wrap0 = (m_t0 == MAXV);
        m_wrap1 = (m_t1 == MAXV);
        m_t0 = (m_t0 + 1) % TWO32;
        m_t1 = (m_t1 + 1) % TWO32;
      end
    end
    m_vi_p = m_vi; m_vi = bus0.inc;
    m_vd_p = m_vd; m_vd = bus0.dec;
    m_armed = m_armed | (!bus0.inc && !bus0.dec);
    m_cyc++;
  endtask

  task automatic compare_all();
    check("t_wrapmode", bus0.t, m_t0);
    check("t_satmode", bus1.t, m_t1);
    check("tick_wrapmode", bus0.tick, m_tick);
    check("tick_satmode", bus1.tick, m_tick);
    check("wrap_wrapmode", bus0.wrap, m_wrap0);
    check("wrap_satmode", bus1.wrap, m_wrap1);
    check("adjust_wrapmode", bus0.adjust, m_adj);
    check("adjust_satmode", bus1.adjust, m_adj);
    check("clamped_wrapmode", bus0.clamped, 1'b0);
    check("clamped_satmode", bus1.clamped, m_clamp1);
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_idle();
    bus0.run = 0; bus0.edit = 0; bus0.inc = 0; bus0.dec = 0;
    bus0.sel = 4'b0001; bus0.load = 0; bus0.load_value = '0;
  endtask

  task automatic load_t(input logic [31:0] v);
    bus0.load = 1; bus0.load_value = v;
    cycle();
    bus0.load = 0;
  endtask

  int adj_cnt, clamp_seen0, clamp_seen1;
  longint adj_at[$];

  initial begin
    total = 0; bad = 0; m_cyc = 0; m_start = 0;
    reset = 1'b0;
    set_idle();
    #1;
    do_reset();

    // Plain counting with a divide-by-4 prescaler.
    bus0.run = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("tick_cadence", bus0.tick, ((i % 4) == 3) ? 1'b1 : 1'b0);
    end
    check("t_after_12", bus0.t, 3);

    // Rollover from all ones.
    load_t(32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) cycle();
    check("rollover_t", bus0.t, 0);
    check("rollover_tick", bus0.tick, 1);
    check("rollover_wrap", bus0.wrap, 1);

    // Hour increment, then an invalid select.
    bus0.run = 0; bus0.edit = 1;
    load_t(32'd100);
    bus0.sel = 4'b0100; bus0.inc = 1;
    adj_cnt = 0;
    cycle(); adj_cnt += bus0.adjust;
    bus0.inc = 0;
    for (int i = 0; i < 4; i++) begin cycle(); adj_cnt += bus0.adjust; end
    check("hour_inc_t", bus0.t, 3700);
    check("hour_inc_adjust_count", adj_cnt, 1);
    bus0.sel = 4'b0011; bus0.inc = 1;
    adj_cnt = 0;
    cycle(); adj_cnt += bus0.adjust;
    bus0.inc = 0;
    for (int i = 0; i < 4; i++) begin cycle(); adj_cnt += bus0.adjust; end
    check("bad_sel_t", bus0.t, 3700);
    check("bad_sel_adjust_count", adj_cnt, 0);

    // Minute decrement below zero: clamp versus wrap.
    load_t(32'd30);
    bus0.sel = 4'b0010; bus0.dec = 1;
    clamp_seen0 = 0; clamp_seen1 = 0;
    cycle();
    bus0.dec = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(); clamp_seen0 += bus0.clamped; clamp_seen1 += bus1.clamped;
    end
    check("sat_dec_t", bus1.t, 0);
    check("sat_dec_clamped", clamp_seen1, 1);
    check("wrap_dec_t", bus0.t, 32'hFFFF_FFE2);
    check("wrap_dec_clamped", clamp_seen0, 0);

    // Held button: first step, then auto-repeat.
    load_t(32'd0);
    bus0.sel = 4'b0001;
    adj_at.delete();
    for (int i = 0; i < 26; i++) begin
      bus0.inc = (i < 20);
      cycle();
      if (bus0.adjust) adj_at.push_back(i);
    end
    check("repeat_t", bus0.t, 5);
    check("repeat_steps", adj_at.size(), 5);
    if (adj_at.size() == 5) begin
      check("repeat_first_gap", adj_at[1] - adj_at[0], 8);
      check("repeat_last_gap", adj_at[4] - adj_at[0], 17);
    end
    check("fsm_idle_after_release", 64'(dut0.u_rep.state), 64'(epoch_pkg::ST_IDLE));

    // Load coinciding with a step pulse.
    load_t(32'd7);
    bus0.inc = 1;
    cycle();
    bus0.load = 1; bus0.load_value = 32'd500;
    adj_cnt = 0;
    cycle(); adj_cnt += bus0.adjust;
    bus0.load = 0; bus0.inc = 0;
    for (int i = 0; i < 3; i++) begin cycle(); adj_cnt += bus0.adjust; end
    check("load_beats_step_t", bus0.t, 500);
    check("load_beats_step_adjust", adj_cnt, 0);

    // Reset in the middle of auto-repeat with the button still held.
    bus0.inc = 1;
    for (int i = 0; i < 14; i++) cycle();
    do_reset();
    check("reset_mid_repeat_t", bus0.t, 0);
    adj_cnt = 0;
    for (int i = 0; i < 15; i++) begin cycle(); adj_cnt += bus0.adjust; end
    check("held_after_reset_adjust", adj_cnt, 0);
    check("held_after_reset_t", bus0.t, 0);
    bus0.inc = 0;
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      bus0.run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 24) == 0) bus0.edit = ~bus0.edit;
      if ($urandom_range(0, 11) == 0) bus0.inc = ~bus0.inc;
      if ($urandom_range(0, 17) == 0) bus0.dec = ~bus0.dec;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 4))
          0: bus0.sel = 4'b0001;
          1: bus0.sel = 4'b0010;
          2: bus0.sel = 4'b0100;
          3: bus0.sel = 4'b1000;
          default: bus0.sel = 4'($urandom);
        endcase
      end
      bus0.load = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 3))
        0: bus0.load_value = $urandom;
        1: bus0.load_value = 32'hFFFF_FFFF - $urandom_range(0, 100000);
        2: bus0.load_value = $urandom_range(0, 100000);
        default: bus0.load_value = 32'hFFFF_FFFD;
      endcase
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/epoch_counter.md
EPOCH_COUNTER -- requirements
Module: epoch_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter width in bits (minimum 18).
REQ-002 SHALL have parameter TICK_DIV, default 100000000, clk cycles per counted second.
REQ-003 SHALL have parameter REPEAT_DELAY, default 50000000, cycles from first step to first auto-repeat step.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 10000000, cycles between subsequent auto-repeat steps.
REQ-005 SHALL have parameter SATURATE, default 0; 0 = edits wrap modulo 2^WIDTH, 1 = edits clamp.
REQ-006 SHALL have ports: clk  in  1  system clock.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 run  in  1  level; enables once-per-second counting.
REQ-009 edit  in  1  level; edit mode, suspends counting, enables inc/dec.
REQ-010 inc  in  1  level button, increment selected field.
REQ-011 dec  in  1  level button, decrement selected field.
REQ-012 sel  in  4  one-hot field select (sec/min/hour/day).
REQ-013 load  in  1  single-cycle load strobe.
REQ-014 load_value  in  WIDTH  value written on load.
REQ-015 t  out  WIDTH  current count (seconds).
REQ-016 tick  out  1  one-cycle pulse per counted second.
REQ-017 wrap  out  1  one-cycle pulse when a tick rolls t from 2^WIDTH-1 to 0.
REQ-018 adjust  out  1  one-cycle pulse on every applied edit step.
REQ-019 clamped  out  1  one-cycle pulse when saturation limited an edit step.

Function
REQ-020 Single clock domain; all state updates on posedge clk; no derived clocks or gated triggers.
REQ-021 Prescaler counts 0..TICK_DIV-1 while run=1 and edit=0; holds otherwise; at TICK_DIV-1 returns to 0 and t increments by 1 with tick=1 in the same cycle.
REQ-022 Tick increment always wraps modulo 2^WIDTH regardless of SATURATE; wrap pulses on rollover.
REQ-023 Step size from sel: 0001->1, 0010->60, 0100->3600, 1000->86400; any other sel -> no step, adjust stays 0.
REQ-024 inc/dec registered once; rising edge detected from registered value; step applied to t one cycle after the edge is registered.
REQ-025 Edit FSM states IDLE, WAIT, REPEAT; direction latched on leaving IDLE.
REQ-026 IDLE->WAIT on rising edge of exactly one of inc/dec with edit=1; one step applied; edges with both inc and dec high ignored.
REQ-027 WAIT->REPEAT after REPEAT_DELAY cycles with latched button held; one step applied at transition.
REQ-028 REPEAT applies one step every REPEAT_PERIOD cycles while latched button held.
REQ-029 Any state -> IDLE on release of latched button, assertion of opposite button, or edit=0; no step on that cycle.
REQ-030 SATURATE=1: decrement below 0 yields 0, increment above 2^WIDTH-1 yields 2^WIDTH-1, clamped=1; SATURATE=0: modulo arithmetic, clamped=0.
REQ-031 Priority per cycle: reset > load > edit step > tick; a lower-priority event coinciding with a higher one is dropped, not deferred.
REQ-032 load sets t=load_value and clears prescaler to 0; edit FSM state unaffected.
REQ-033 Leaving edit mode resumes prescaler from its held value.

Reset
REQ-034 Reset asserts asynchronously: t=0, prescaler=0, repeat timer=0, FSM=IDLE, button registers=0, tick/wrap/adjust/clamped=0.
REQ-035 Reset mid-hold: after release, a still-held button produces no step until released and pressed again.

Structure
REQ-036 Package epoch_pkg SHALL hold step constants (1, 60, 3600, 86400), sel one-hot encodings, and edit FSM state enum.
REQ-037 One sub-module edit_repeater (edge detect, FSM, repeat timer) SHALL output one-cycle step_inc/step_dec; epoch_counter owns prescaler and arithmetic.

Verification
REQ-038 TICK_DIV=4, run=1, edit=0 for 12 cycles from reset -> t=3, tick high on cycles 4, 8, 12.
REQ-039 load_value=2^32-1, then one tick -> t=0, tick and wrap pulse together.
REQ-040 edit=1, sel=0100, inc pulse 1 cycle from t=100 -> t=3700, adjust one pulse; sel=0011 inc -> t unchanged.
REQ-041 SATURATE=1, t=30, sel=0010, dec pressed -> t=0, clamped=1; SATURATE=0 same -> t=2^32-30.
REQ-042 REPEAT_DELAY=8, REPEAT_PERIOD=3, sel=0001, inc held 20 cycles from t=0 -> steps at first edge, +8, +11, +14, +17; t=5; release -> FSM IDLE.
REQ-043 load and inc edge in same cycle, load_value=500 -> t=500, adjust=0; reset asserted mid-REPEAT -> t=0 immediately, no step while held.
